// File: rtl/cnn_axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_axil_pkg
//  Description : Shared constants for the CNN control AXI4-Lite register
//                block: response codes, register slot indices and the
//                write-response decode helper.
//  Revision    : 1.0  initial release
// ============================================================================
package cnn_axil_pkg;

    typedef enum logic [1:0] {
        C_RESP_OKAY   = 2'b00,
        C_RESP_EXOKAY = 2'b01,
        C_RESP_SLVERR = 2'b10,
        C_RESP_DECERR = 2'b11
    } axi_resp_t;

    localparam int C_SLOT_CTRL     = 0;
    localparam int C_SLOT_STATUS   = 1;
    localparam int C_SLOT_CFG_BASE = 2;

    // Response for a write landing on a given slot. STATUS is read-only and
    // anything past the last implemented slot is not decoded.
    function automatic axi_resp_t write_resp(input int slot, input int num_regs);
        if (slot >= num_regs) begin
            return C_RESP_DECERR;
        end else if (slot == C_SLOT_STATUS) begin
            return C_RESP_SLVERR;
        end else begin
            return C_RESP_OKAY;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_ctrl_axil_slave.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_ctrl_axil_slave
//  Description : AXI4-Lite register slave for the CNN core.
//                slot0 CTRL   : write bit0=1 pulses ctrl_start, reads 0
//                slot1 STATUS : read-only view of status_in
//                slot2..N-1   : CFG read/write registers, byte-strobed
//  Ports       : aclk/areset         clock, synchronous active-high reset
//                s_axi_aw*/w*/b*     AXI4-Lite write channels
//                s_axi_ar*/r*        AXI4-Lite read channels
//                ctrl_start          one-cycle start pulse to the core
//                status_in           core status word
//                cfg_regs            CFG slots flattened, slot 2 in the LSBs
//  Revision    : 1.0  initial release
// ============================================================================
module cnn_ctrl_axil_slave
    import cnn_axil_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [ADDR_W-1:0]                s_axi_awaddr,
    input  logic                             s_axi_awvalid,
    output logic                             s_axi_awready,
    input  logic [DATA_W-1:0]                s_axi_wdata,
    input  logic [DATA_W/8-1:0]              s_axi_wstrb,
    input  logic                             s_axi_wvalid,
    output logic                             s_axi_wready,
    output logic [1:0]                       s_axi_bresp,
    output logic                             s_axi_bvalid,
    input  logic                             s_axi_bready,
    input  logic [ADDR_W-1:0]                s_axi_araddr,
    input  logic                             s_axi_arvalid,
    output logic                             s_axi_arready,
    output logic [DATA_W-1:0]                s_axi_rdata,
    output logic [1:0]                       s_axi_rresp,
    output logic                             s_axi_rvalid,
    input  logic                             s_axi_rready,
    output logic                             ctrl_start,
    input  logic [DATA_W-1:0]                status_in,
    output logic [DATA_W*(NUM_REGS-2)-1:0]   cfg_regs
);

    localparam int C_SLOT_W    = ADDR_W - 2;
    localparam int C_NUM_CFG   = NUM_REGS - C_SLOT_CFG_BASE;
    localparam int C_NUM_BYTES = DATA_W / 8;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic                   r_awready;
    logic                   r_wready;
    logic                   r_aw_full;
    logic                   r_w_full;
    logic [C_SLOT_W-1:0]    r_awslot;
    logic [DATA_W-1:0]      r_wdata;
    logic [C_NUM_BYTES-1:0] r_wstrb;
    logic                   r_bvalid;
    axi_resp_t              r_bresp;
    logic                   r_ctrl_start;
    logic [DATA_W-1:0]      r_cfg [C_NUM_CFG];

    logic w_aw_hs;
    logic w_w_hs;
    logic w_commit;
    int   w_wslot;

    assign w_aw_hs  = s_axi_awvalid & r_awready;
    assign w_w_hs   = s_axi_wvalid & r_wready;
    assign w_commit = r_aw_full & r_w_full;
    assign w_wslot  = int'(r_awslot);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_awready    <= 1'b0;
            r_wready     <= 1'b0;
            r_aw_full    <= 1'b0;
            r_w_full     <= 1'b0;
            r_awslot     <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_bvalid     <= 1'b0;
            r_bresp      <= C_RESP_OKAY;
            r_ctrl_start <= 1'b0;
            for (int i = 0; i < C_NUM_CFG; i++) begin
                r_cfg[i] <= '0;
            end
        end else begin
            r_ctrl_start <= 1'b0;

            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_awslot  <= s_axi_awaddr[ADDR_W-1:2];
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_wdata  <= s_axi_wdata;
                r_wstrb  <= s_axi_wstrb;
            end

            // Both halves are held in the latches for one cycle before the
            // commit; the readys are already low, so nothing new can arrive.
            if (w_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= write_resp(w_wslot, NUM_REGS);
                if (w_wslot == C_SLOT_CTRL) begin
                    r_ctrl_start <= r_wdata[0] & r_wstrb[0];
                end
                for (int i = 0; i < C_NUM_CFG; i++) begin
                    if (w_wslot == i + C_SLOT_CFG_BASE) begin
                        for (int b = 0; b < C_NUM_BYTES; b++) begin
                            if (r_wstrb[b]) begin
                                r_cfg[i][8*b +: 8] <= r_wdata[8*b +: 8];
                            end
                        end
                    end
                end
            end else if (r_bvalid && s_axi_bready) begin
                r_bvalid <= 1'b0;
            end

            // Built from the current state, so the readys come back one
            // cycle after bvalid drops; a handshake closes them at once.
            r_awready <= !w_aw_hs && !r_aw_full && !r_bvalid;
            r_wready  <= !w_w_hs && !r_w_full && !r_bvalid;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic              r_arready;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    axi_resp_t         r_rresp;

    logic              w_ar_hs;
    int                w_rslot;
    logic [DATA_W-1:0] w_rdata_next;
    axi_resp_t         w_rresp_next;

    assign w_ar_hs = s_axi_arvalid & r_arready;
    assign w_rslot = int'(s_axi_araddr[ADDR_W-1:2]);

    always_comb begin
        w_rdata_next = '0;
        w_rresp_next = C_RESP_OKAY;
        if (w_rslot >= NUM_REGS) begin
            w_rresp_next = C_RESP_DECERR;
        end else if (w_rslot == C_SLOT_STATUS) begin
            w_rdata_next = status_in;
        end else begin
            for (int i = 0; i < C_NUM_CFG; i++) begin
                if (w_rslot == i + C_SLOT_CFG_BASE) begin
                    w_rdata_next = r_cfg[i];
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= C_RESP_OKAY;
        end else if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rdata_next;
            r_rresp   <= w_rresp_next;
        end else if (r_rvalid && s_axi_rready) begin
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
        end else begin
            r_arready <= !r_rvalid;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign ctrl_start    = r_ctrl_start;

    generate
        for (genvar gi = 0; gi < C_NUM_CFG; gi++) begin : g_cfg_out
            assign cfg_regs[gi*DATA_W +: DATA_W] = r_cfg[gi];
        end
    endgenerate

    // Byte-lane bits of the addresses carry no decode information.
    logic w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_cnn_ctrl_axil_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnn_ctrl_axil_slave
//  Description : Self-checking bench for cnn_ctrl_axil_slave (NUM_REGS=7, so
//                slot 7 at 0x1C is unmapped). Directed vector table plus
//                hand-written multi-cycle sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cnn_ctrl_axil_slave;

    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 7;
    localparam int CFG_W    = 32 * (NUM_REGS - 2);

    logic              clk = 1'b0;
    logic              areset;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic              ctrl_start;
    logic [31:0]       status_in;
    logic [CFG_W-1:0]  cfg_regs;

    cnn_ctrl_axil_slave #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (32),
        .NUM_REGS (NUM_REGS)
    ) u_dut (
        .aclk          (clk),
        .areset        (areset),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .ctrl_start    (ctrl_start),
        .status_in     (status_in),
        .cfg_regs      (cfg_regs)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    int pulse_unaligned = 0;

    // ctrl_start must coincide with the first bvalid cycle of the commit.
    always @(negedge clk) begin
        if (ctrl_start === 1'b1) begin
            pulse_cnt++;
            if (bvalid !== 1'b1) pulse_unaligned++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    // AW and W presented together; bready held high by the caller.
    task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        bit got     = 0;
        resp    = 2'b00;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready)   w_done  = 1;
            @(negedge clk);
            if (aw_done) awvalid = 1'b0;
            if (w_done)  wvalid  = 1'b0;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bvalid) begin
                resp = bresp;
                got  = 1;
                break;
            end
            @(negedge clk);
        end
        check("write_bvalid_seen", 32'(got), 32'd1);
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        bit got = 0;
        data    = '0;
        resp    = 2'b00;
        araddr  = addr;
        arvalid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (arready) begin
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        arvalid = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (rvalid) begin
                data = rdata;
                resp = rresp;
                got  = 1;
                break;
            end
            @(negedge clk);
        end
        check("read_rvalid_seen", 32'(got), 32'd1);
        @(negedge clk);
    endtask

    typedef struct {
        bit                is_wr;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        strb;
        logic [31:0]       status;
        logic [31:0]       exp_rdata;
        logic [1:0]        exp_resp;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    logic [1:0]  r_resp;
    logic [31:0] r_data;
    int          pulses0;

    initial begin
        // Expected state entering the table: slot2=DEADBEEF, slot3=00005678.
        vecs[0]  = '{1'b1, 5'h10, 32'h11223344, 4'hF, 32'h0,    32'h0,        2'b00};
        vecs[1]  = '{1'b1, 5'h11, 32'hAABBCCDD, 4'h5, 32'h0,    32'h0,        2'b00};
        vecs[2]  = '{1'b0, 5'h10, 32'h0,        4'h0, 32'h0,    32'h11BB33DD, 2'b00};
        vecs[3]  = '{1'b1, 5'h14, 32'hFFFFFFFF, 4'h0, 32'h0,    32'h0,        2'b00};
        vecs[4]  = '{1'b0, 5'h16, 32'h0,        4'h0, 32'h0,    32'h0,        2'b00};
        vecs[5]  = '{1'b1, 5'h18, 32'hCAFEF00D, 4'hF, 32'h0,    32'h0,        2'b00};
        vecs[6]  = '{1'b0, 5'h18, 32'h0,        4'h0, 32'h0,    32'hCAFEF00D, 2'b00};
        vecs[7]  = '{1'b1, 5'h1C, 32'h00000001, 4'hF, 32'h0,    32'h0,        2'b11};
        vecs[8]  = '{1'b0, 5'h08, 32'h0,        4'h0, 32'h0,    32'hDEADBEEF, 2'b00};
        vecs[9]  = '{1'b0, 5'h0C, 32'h0,        4'h0, 32'h0,    32'h00005678, 2'b00};
        vecs[10] = '{1'b0, 5'h04, 32'h0,        4'h0, 32'hA5A5, 32'h0000A5A5, 2'b00};
        vecs[11] = '{1'b1, 5'h04, 32'h12345678, 4'hF, 32'hA5A5, 32'h0,        2'b10};
        vecs[12] = '{1'b0, 5'h04, 32'h0,        4'h0, 32'hA5A5, 32'h0000A5A5, 2'b00};
        vecs[13] = '{1'b1, 5'h00, 32'h00000000, 4'hF, 32'h0,    32'h0,        2'b00};
        vecs[14] = '{1'b1, 5'h00, 32'h00000001, 4'hE, 32'h0,    32'h0,        2'b00};
        vecs[15] = '{1'b1, 5'h00, 32'h00000001, 4'h1, 32'h0,    32'h0,        2'b00};
        vecs[16] = '{1'b0, 5'h00, 32'h0,        4'h0, 32'h0,    32'h0,        2'b00};
        vecs[17] = '{1'b0, 5'h1C, 32'h0,        4'h0, 32'h0,    32'h0,        2'b11};

        areset = 1'b1; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
        bready = 1'b1; araddr = '0; arvalid = 0; rready = 1'b1; status_in = '0;

        // ---------------- reset state ----------------
        idle(3);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready",  32'(wready),  32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_ctrl_start", 32'(ctrl_start), 32'd0);
        check("rst_rdata",   rdata, 32'h0);
        check("rst_cfg_or",  32'(|cfg_regs), 32'd0);
        areset = 1'b0;
        @(negedge clk);
        check("rel_awready", 32'(awready), 32'd1);
        check("rel_wready",  32'(wready),  32'd1);
        check("rel_arready", 32'(arready), 32'd1);

        // ---------------- same-cycle AW+W to slot2 ----------------
        awaddr = 5'h08; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        check("samecyc_bvalid_c1", 32'(bvalid), 32'd0);
        check("samecyc_awready_c1", 32'(awready), 32'd0);
        @(negedge clk);
        check("samecyc_bvalid_c2", 32'(bvalid), 32'd1);
        check("samecyc_bresp", 32'(bresp), 32'd0);
        check("samecyc_cfg2", cfg_regs[31:0], 32'hDEADBEEF);
        @(negedge clk);
        check("samecyc_bvalid_drop", 32'(bvalid), 32'd0);
        check("samecyc_awready_still_low", 32'(awready), 32'd0);
        @(negedge clk);
        check("samecyc_awready_back", 32'(awready), 32'd1);
        check("samecyc_wready_back",  32'(wready),  32'd1);

        // ---------------- W first, AW three cycles later ----------------
        wdata = 32'h12345678; wstrb = 4'h3; wvalid = 1;
        @(negedge clk);
        wvalid = 0;
        check("wfirst_wready_low", 32'(wready), 32'd0);
        check("wfirst_awready_high", 32'(awready), 32'd1);
        idle(2);
        awaddr = 5'h0C; awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        check("wfirst_bvalid_c1", 32'(bvalid), 32'd0);
        @(negedge clk);
        check("wfirst_bvalid_c2", 32'(bvalid), 32'd1);
        check("wfirst_bresp", 32'(bresp), 32'd0);
        check("wfirst_cfg3", cfg_regs[63:32], 32'h00005678);
        idle(2);

        // ---------------- vector table ----------------
        pulses0 = pulse_cnt;
        for (int i = 0; i < NVEC; i++) begin
            status_in = vecs[i].status;
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r_resp);
                check($sformatf("vec%0d_bresp", i), 32'(r_resp), 32'(vecs[i].exp_resp));
            end else begin
                axi_read(vecs[i].addr, r_data, r_resp);
                check($sformatf("vec%0d_rresp", i), 32'(r_resp), 32'(vecs[i].exp_resp));
                check($sformatf("vec%0d_rdata", i), r_data, vecs[i].exp_rdata);
            end
            idle(1);
        end
        check("ctrl_start_cycles", 32'(pulse_cnt - pulses0), 32'd1);
        check("ctrl_start_aligned", 32'(pulse_unaligned), 32'd0);
        check("cfg_slot2", cfg_regs[31:0],    32'hDEADBEEF);
        check("cfg_slot3", cfg_regs[63:32],   32'h00005678);
        check("cfg_slot4", cfg_regs[95:64],   32'h11BB33DD);
        check("cfg_slot5", cfg_regs[127:96],  32'h00000000);
        check("cfg_slot6", cfg_regs[159:128], 32'hCAFEF00D);

        // ---------------- read racing a commit to the same slot ----------------
        awaddr = 5'h10; wdata = 32'h55555555; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        araddr = 5'h10; arvalid = 1;
        @(negedge clk);
        arvalid = 0;
        check("race_bvalid", 32'(bvalid), 32'd1);
        check("race_rvalid", 32'(rvalid), 32'd1);
        check("race_rdata_old", rdata, 32'h11BB33DD);
        idle(2);
        axi_read(5'h10, r_data, r_resp);
        check("race_rdata_new", r_data, 32'h55555555);
        idle(1);

        // ---------------- unmapped read with rready stalled ----------------
        rready = 0; araddr = 5'h1C; arvalid = 1;
        @(negedge clk);
        arvalid = 0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d_rvalid", k), 32'(rvalid), 32'd1);
            check($sformatf("stall%0d_rresp", k), 32'(rresp), 32'd3);
            check($sformatf("stall%0d_rdata", k), rdata, 32'h0);
            check($sformatf("stall%0d_arready", k), 32'(arready), 32'd0);
            @(negedge clk);
        end
        rready = 1;
        @(negedge clk);
        check("stall_rvalid_drop", 32'(rvalid), 32'd0);
        check("stall_arready_back", 32'(arready), 32'd1);

        // ---------------- STATUS sampled at the AR handshake ----------------
        rready = 0; status_in = 32'h1111; araddr = 5'h04; arvalid = 1;
        @(negedge clk);
        arvalid = 0; status_in = 32'h2222;
        idle(2);
        check("status_hold_rvalid", 32'(rvalid), 32'd1);
        check("status_hold_rdata", rdata, 32'h1111);
        rready = 1;
        idle(2);

        // ---------------- reset with AW latched and W pending ----------------
        awaddr = 5'h08; awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        check("abort_awready_low", 32'(awready), 32'd0);
        areset = 1; wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1;
        idle(2);
        check("abort_rst_wready", 32'(wready), 32'd0);
        check("abort_rst_bvalid", 32'(bvalid), 32'd0);
        areset = 0; wvalid = 0;
        @(negedge clk);
        check("abort_awready", 32'(awready), 32'd1);
        check("abort_wready",  32'(wready),  32'd1);
        check("abort_arready", 32'(arready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("abort_no_bvalid%0d", k), 32'(bvalid), 32'd0);
            @(negedge clk);
        end
        check("abort_cfg_slot2", cfg_regs[31:0],    32'h0);
        check("abort_cfg_slot3", cfg_regs[63:32],   32'h0);
        check("abort_cfg_slot4", cfg_regs[95:64],   32'h0);
        check("abort_cfg_slot5", cfg_regs[127:96],  32'h0);
        check("abort_cfg_slot6", cfg_regs[159:128], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
